// File: rtl/float_op_issuer_pkg.sv
// Shared definitions for the float_alu requester front-end: op codes, flag
// bit positions, canonical NaN, FSM state encoding and the ALU command payload.
package float_op_issuer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned STALE_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV = 3'd3;

  // Bit positions inside the 5-bit XZOUI flag vector
  localparam int unsigned FLAG_X = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_O = 2;
  localparam int unsigned FLAG_U = 1;
  localparam int unsigned FLAG_I = 0;

  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [OP_W-1:0]   op_code;
    logic              round_mode;
    logic              mode_fp;
  } alu_cmd_t;

endpackage

// File: rtl/float_op_watchdog.sv
// Cycle counter for the WAIT state; freezes once it reaches LIMIT so the
// expiry indication cannot wrap away.
module float_op_watchdog #(
  parameter int unsigned CNT_W = 7,
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/float_op_issuer.sv
// Requester front-end for float_alu: one outstanding op, tagged responses,
// sticky XZOUI accumulation, watchdog timeout and stale-result discard.
module float_op_issuer
  import float_op_issuer_pkg::*;
#(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_op_a,
  input  logic [DATA_W-1:0]   cmd_op_b,
  input  logic [OP_W-1:0]     cmd_op_code,
  input  logic                cmd_round_mode,
  input  logic                cmd_mode_fp,
  input  logic [TAG_W-1:0]    cmd_tag,
  output logic [DATA_W-1:0]   alu_op_a,
  output logic [DATA_W-1:0]   alu_op_b,
  output logic [OP_W-1:0]     alu_op_code,
  output logic                alu_round_mode,
  output logic                alu_mode_fp,
  output logic                alu_start,
  output logic                alu_ready_in,
  input  logic                alu_ready_out,
  input  logic                alu_valid_out,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [FLAG_W-1:0]   alu_flags,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_result,
  output logic [FLAG_W-1:0]   rsp_flags,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_timeout,
  output logic [FLAG_W-1:0]   acc_flags,
  input  logic                acc_clr,
  output logic [STALE_W-1:0]  stale_drops
);

  state_e           state_q, state_d;
  alu_cmd_t         cmd_q;
  logic [TAG_W-1:0] tag_q;
  logic             wd_expired_c;
  logic             accept_c, capture_c, timeout_c, stale_c;

  assign accept_c  = (state_q == ST_IDLE) && cmd_valid;
  assign capture_c = (state_q == ST_WAIT) && alu_valid_out;
  assign timeout_c = (state_q == ST_WAIT) && !alu_valid_out && wd_expired_c;
  assign stale_c   = ((state_q == ST_IDLE) || (state_q == ST_ISSUE)) && alu_valid_out;

  assign cmd_ready    = (state_q == ST_IDLE);
  assign alu_ready_in = (state_q != ST_RESP);

  assign alu_op_a       = cmd_q.op_a;
  assign alu_op_b       = cmd_q.op_b;
  assign alu_op_code    = cmd_q.op_code;
  assign alu_round_mode = cmd_q.round_mode;
  assign alu_mode_fp    = cmd_q.mode_fp;

  float_op_watchdog #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state_q != ST_WAIT),
    .en        (state_q == ST_WAIT),
    .expired_c (wd_expired_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cmd_valid)                state_d = ST_ISSUE;
      ST_ISSUE: if (alu_ready_out)            state_d = ST_WAIT;
      ST_WAIT:  if (capture_c || timeout_c)   state_d = ST_RESP;
      ST_RESP:  if (rsp_ready)                state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Registered command, handshake, response and bookkeeping outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      tag_q       <= '0;
      alu_start   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_tag     <= '0;
      rsp_timeout <= 1'b0;
      acc_flags   <= '0;
      stale_drops <= '0;
    end else begin
      alu_start <= (state_q == ST_ISSUE) && alu_ready_out;

      if (accept_c) begin
        cmd_q <= '{op_a: cmd_op_a, op_b: cmd_op_b, op_code: cmd_op_code,
                   round_mode: cmd_round_mode, mode_fp: cmd_mode_fp};
        tag_q <= cmd_tag;
      end

      if (capture_c) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= alu_result;
        rsp_flags   <= alu_flags;
        rsp_tag     <= tag_q;
        rsp_timeout <= 1'b0;
      end else if (timeout_c) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= QNAN;
        rsp_flags   <= '0;
        rsp_tag     <= tag_q;
        rsp_timeout <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid   <= 1'b0;
      end

      // A clear coinciding with a capture keeps only the new flags
      if (capture_c) begin
        acc_flags <= (acc_clr ? '0 : acc_flags) | alu_flags;
      end else if (acc_clr) begin
        acc_flags <= '0;
      end

      if (stale_c && (stale_drops != '1)) begin
        stale_drops <= stale_drops + STALE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_float_op_issuer.sv
// Self-checking bench for float_op_issuer with a stub float_alu and a
// transaction-level expectation model.
module tb_float_op_issuer;
  import float_op_issuer_pkg::*;

  localparam int unsigned TAG_W          = 4;
  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam int unsigned CNT_W          = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [31:0]       cmd_op_a = '0;
  logic [31:0]       cmd_op_b = '0;
  logic [2:0]        cmd_op_code = '0;
  logic              cmd_round_mode = 1'b0;
  logic              cmd_mode_fp = 1'b0;
  logic [TAG_W-1:0]  cmd_tag = '0;
  logic [31:0]       alu_op_a, alu_op_b;
  logic [2:0]        alu_op_code;
  logic              alu_round_mode, alu_mode_fp, alu_start, alu_ready_in;
  logic              alu_ready_out = 1'b0;
  logic              alu_valid_out = 1'b0;
  logic [31:0]       alu_result = '0;
  logic [4:0]        alu_flags = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_result;
  logic [4:0]        rsp_flags;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_timeout;
  logic [4:0]        acc_flags;
  logic              acc_clr = 1'b0;
  logic [7:0]        stale_drops;

  int         checks = 0;
  int         failures = 0;
  logic [4:0] exp_acc = '0;

  typedef struct {
    logic [31:0]      result;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
    logic             timeout;
    logic [4:0]       acc;
    int               start_cyc;
    int               starts;
    int               rsp_cyc;
    bit               ready_viol;
  } obs_t;

  always #5 clk = ~clk;

  float_op_issuer #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_op_code(cmd_op_code),
    .cmd_round_mode(cmd_round_mode), .cmd_mode_fp(cmd_mode_fp), .cmd_tag(cmd_tag),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_round_mode(alu_round_mode), .alu_mode_fp(alu_mode_fp),
    .alu_start(alu_start), .alu_ready_in(alu_ready_in),
    .alu_ready_out(alu_ready_out), .alu_valid_out(alu_valid_out),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .rsp_timeout(rsp_timeout), .acc_flags(acc_flags), .acc_clr(acc_clr),
    .stale_drops(stale_drops)
  );

  function automatic logic [125:0] reg_outs();
    return {alu_op_a, alu_op_b, alu_op_code, alu_round_mode, alu_mode_fp, alu_start,
            rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout, acc_flags, stale_drops};
  endfunction

  // Issue one command from IDLE and act as the ALU; cycle 0 is the accept cycle.
  // busy: cycles 1..busy see ready_out=0. lat: valid_out lat cycles after start (<0: never).
  task automatic drive_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [TAG_W-1:0] tag, input logic [31:0] res,
                           input logic [4:0] flg, input int busy, input int lat,
                           input bit clr, output obs_t o);
    int c;
    o = '{default: 0};
    o.start_cyc = -1;
    o.rsp_cyc   = -1;
    cmd_valid = 1'b1; cmd_op_a = a; cmd_op_b = b; cmd_op_code = op;
    cmd_round_mode = 1'b0; cmd_mode_fp = 1'b1; cmd_tag = tag;
    alu_ready_out = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op_a = $urandom; cmd_op_b = $urandom; cmd_tag = TAG_W'($urandom);
    c = 1;
    while (c < 400 && rsp_valid !== 1'b1) begin
      if (alu_start === 1'b1) begin
        o.starts++;
        if (o.start_cyc < 0) o.start_cyc = c;
      end
      if (cmd_ready !== 1'b0) o.ready_viol = 1'b1;
      alu_ready_out = (c > busy);
      if (lat >= 0 && o.start_cyc >= 0 && c == o.start_cyc + lat) begin
        alu_valid_out = 1'b1; alu_result = res; alu_flags = flg; acc_clr = clr;
      end else begin
        alu_valid_out = 1'b0; alu_result = $urandom; alu_flags = 5'($urandom); acc_clr = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    alu_valid_out = 1'b0;
    acc_clr = 1'b0;
    if (rsp_valid === 1'b1) begin
      o.rsp_cyc = c; o.result = rsp_result; o.flags = rsp_flags; o.tag = rsp_tag;
      o.timeout = rsp_timeout; o.acc = acc_flags;
      if (cmd_ready !== 1'b0) o.ready_viol = 1'b1;
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (reg_outs() !== '0) begin
      failures++; $display("FAIL reset_regs: got %h expected 0", reg_outs());
    end
    checks++;
    if ({cmd_ready, alu_ready_in} !== 2'b11) begin
      failures++; $display("FAIL reset_ready: got %b expected 11", {cmd_ready, alu_ready_in});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    obs_t o;
    drive_txn(32'h41A6_0000, 32'h4010_0000, OP_MUL, 4'd3, 32'h423A_C000, 5'b00000, 0, 3, 1'b0, o);
    checks++;
    if ({o.result, o.flags, o.tag, o.timeout, o.acc} !== {32'h423A_C000, 5'b0, 4'd3, 1'b0, 5'b0}) begin
      failures++; $display("FAIL b2b_rsp1: got %h/%b/%h/%b/%b expected 423ac000/00000/3/0/00000",
                           o.result, o.flags, o.tag, o.timeout, o.acc);
    end
    checks++;
    if (o.start_cyc != 2 || o.starts != 1 || o.rsp_cyc != 6) begin
      failures++; $display("FAIL b2b_latency: got start=%0d n=%0d rsp=%0d expected start=2 n=1 rsp=6",
                           o.start_cyc, o.starts, o.rsp_cyc);
    end
    checks++;
    if ({alu_op_a, alu_op_b, alu_op_code} !== {32'h41A6_0000, 32'h4010_0000, OP_MUL}) begin
      failures++; $display("FAIL b2b_cmd_hold: got %h %h %0d expected 41a60000 40100000 %0d",
                           alu_op_a, alu_op_b, alu_op_code, OP_MUL);
    end
    ack_rsp();
    drive_txn(32'hC144_0000, 32'h4160_0000, OP_MUL, 4'd7, 32'hC32B_8000, 5'b00000, 0, 1, 1'b0, o);
    checks++;
    if ({o.result, o.flags, o.tag, o.timeout} !== {32'hC32B_8000, 5'b0, 4'd7, 1'b0}) begin
      failures++; $display("FAIL b2b_rsp2: got %h/%b/%h/%b expected c32b8000/00000/7/0",
                           o.result, o.flags, o.tag, o.timeout);
    end
    checks++;
    if (o.ready_viol) begin
      failures++; $display("FAIL b2b_cmd_ready: got high between accept and handshake expected low");
    end
    ack_rsp();
  endtask

  task automatic test_overflow_sticky();
    obs_t o;
    drive_txn(32'h7F7F_FFFF, 32'h7F7F_FFFF, OP_MUL, 4'd1, 32'h7F80_0000, 5'b00101, 0, 2, 1'b0, o);
    exp_acc = exp_acc | 5'b00101;
    checks++;
    if ({o.result, o.flags, o.acc} !== {32'h7F80_0000, 5'b00101, exp_acc}) begin
      failures++; $display("FAIL ovf_rsp: got %h/%b acc=%b expected 7f800000/00101 acc=%b",
                           o.result, o.flags, o.acc, exp_acc);
    end
    ack_rsp();
    drive_txn(32'h7FC0_0000, 32'hC188_28F6, OP_MUL, 4'd2, 32'h7FC0_0000, 5'b10000, 0, 4, 1'b0, o);
    exp_acc = exp_acc | 5'b10000;
    checks++;
    if ({o.result, o.acc} !== {32'h7FC0_0000, 5'b10101}) begin
      failures++; $display("FAIL nan_sticky: got %h acc=%b expected 7fc00000 acc=10101", o.result, o.acc);
    end
    ack_rsp();
    drive_txn(32'h3F80_0000, 32'h4040_0000, OP_DIV, 4'd4, 32'h3EAA_AAAB, 5'b00001, 0, 2, 1'b1, o);
    exp_acc = 5'b00001;
    checks++;
    if (o.acc !== exp_acc) begin
      failures++; $display("FAIL clr_on_capture: got acc=%b expected %b", o.acc, exp_acc);
    end
    ack_rsp();
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    exp_acc = '0;
    checks++;
    if (acc_flags !== exp_acc) begin
      failures++; $display("FAIL clr_alone: got acc=%b expected 00000", acc_flags);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [31:0] res;
    logic [4:0]  flg;
    bit bad;
    res = $urandom; flg = 5'($urandom);
    drive_txn($urandom, $urandom, OP_ADD, 4'd9, res, flg, 0, 2, 1'b0, o);
    exp_acc = exp_acc | flg;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ({rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout, alu_ready_in, cmd_ready}
          !== {1'b1, res, flg, 4'd9, 1'b0, 1'b0, 1'b0}) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL backpressure_hold: got %b %h %b %h rdy_in=%b cmd_rdy=%b expected 1 %h %b 9 0 0",
                           rsp_valid, rsp_result, rsp_flags, rsp_tag, alu_ready_in, cmd_ready, res, flg);
    end
    ack_rsp();
    checks++;
    if ({rsp_valid, cmd_ready, alu_ready_in} !== 3'b011) begin
      failures++; $display("FAIL backpressure_release: got valid/cmd_rdy/rdy_in=%b expected 011",
                           {rsp_valid, cmd_ready, alu_ready_in});
    end
  endtask

  task automatic test_alu_busy();
    obs_t o;
    logic [4:0] flg;
    flg = 5'($urandom);
    drive_txn($urandom, $urandom, OP_SUB, 4'd5, $urandom, flg, 5, 1, 1'b0, o);
    exp_acc = exp_acc | flg;
    checks++;
    if (o.start_cyc != 7 || o.starts != 1 || o.rsp_cyc != 9) begin
      failures++; $display("FAIL busy_start: got start=%0d n=%0d rsp=%0d expected start=7 n=1 rsp=9",
                           o.start_cyc, o.starts, o.rsp_cyc);
    end
    ack_rsp();
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] res;
    logic [4:0]  flg;
    logic [TAG_W-1:0] tag;
    int busy, lat, hold;
    bit clr;
    for (int i = 0; i < 20; i++) begin
      res = $urandom; flg = 5'($urandom); tag = TAG_W'($urandom);
      busy = $urandom_range(3, 0); lat = $urandom_range(6, 0); hold = $urandom_range(3, 0);
      clr = ($urandom_range(3, 0) == 0);
      drive_txn($urandom, $urandom, 3'($urandom), tag, res, flg, busy, lat, clr, o);
      exp_acc = (clr ? 5'b0 : exp_acc) | flg;
      checks++;
      if ({o.result, o.flags, o.tag, o.timeout, o.acc} !== {res, flg, tag, 1'b0, exp_acc}) begin
        failures++; $display("FAIL rand_rsp[%0d]: got %h/%b/%h/%b acc=%b expected %h/%b/%h/0 acc=%b",
                             i, o.result, o.flags, o.tag, o.timeout, o.acc, res, flg, tag, exp_acc);
      end
      checks++;
      if (o.start_cyc != busy + 2 || o.starts != 1 || o.rsp_cyc != busy + 3 + lat || o.ready_viol) begin
        failures++; $display("FAIL rand_timing[%0d]: got start=%0d n=%0d rsp=%0d viol=%0d expected start=%0d n=1 rsp=%0d viol=0",
                             i, o.start_cyc, o.starts, o.rsp_cyc, o.ready_viol, busy + 2, busy + 3 + lat);
      end
      repeat (hold) @(negedge clk);
      ack_rsp();
    end
  endtask

  task automatic test_watchdog_stale();
    obs_t o;
    drive_txn($urandom, $urandom, OP_DIV, 4'd11, $urandom, 5'b11111, 0, -1, 1'b0, o);
    checks++;
    if ({o.result, o.flags, o.tag, o.timeout, o.acc} !== {QNAN, 5'b0, 4'd11, 1'b1, exp_acc}) begin
      failures++; $display("FAIL timeout_rsp: got %h/%b/%h/%b acc=%b expected 7fc00000/00000/b/1 acc=%b",
                           o.result, o.flags, o.tag, o.timeout, o.acc, exp_acc);
    end
    checks++;
    if (o.rsp_cyc != o.start_cyc + int'(TIMEOUT_CYCLES) + 1) begin
      failures++; $display("FAIL timeout_cycles: got rsp=%0d expected %0d",
                           o.rsp_cyc, o.start_cyc + int'(TIMEOUT_CYCLES) + 1);
    end
    ack_rsp();
    alu_valid_out = 1'b1; alu_result = $urandom; alu_flags = 5'b11111;
    @(negedge clk);
    alu_valid_out = 1'b0;
    checks++;
    if ({stale_drops, rsp_valid, cmd_ready, acc_flags} !== {8'd1, 1'b0, 1'b1, exp_acc}) begin
      failures++; $display("FAIL stale_drop: got drops=%0d valid=%b cmd_rdy=%b acc=%b expected 1 0 1 %b",
                           stale_drops, rsp_valid, cmd_ready, acc_flags, exp_acc);
    end
    alu_valid_out = 1'b1;
    repeat (300) @(negedge clk);
    alu_valid_out = 1'b0;
    checks++;
    if ({stale_drops, rsp_valid} !== {8'd255, 1'b0}) begin
      failures++; $display("FAIL stale_saturate: got drops=%0d valid=%b expected 255 0", stale_drops, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    bit seen;
    cmd_valid = 1'b1; cmd_op_a = 32'h1234_5678; cmd_op_b = 32'h9ABC_DEF0; cmd_tag = 4'd6;
    @(negedge clk);
    cmd_valid = 1'b0; alu_ready_out = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({reg_outs(), cmd_ready, alu_ready_in} !== {126'b0, 2'b11}) begin
      failures++; $display("FAIL reset_mid_wait: got %h rdy=%b expected 0 rdy=11",
                           reg_outs(), {cmd_ready, alu_ready_in});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_acc = '0;
    seen = 1'b0;
    repeat (8) begin
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL reset_no_rsp: got rsp_valid=%b cmd_ready=%b expected 0 1", rsp_valid, cmd_ready);
    end
    drive_txn(32'h4000_0000, 32'h4000_0000, OP_ADD, 4'd8, 32'h4080_0000, 5'b00000, 0, 2, 1'b0, o);
    checks++;
    if ({o.result, o.flags, o.tag, o.timeout, o.acc} !== {32'h4080_0000, 5'b0, 4'd8, 1'b0, 5'b0}
        || o.start_cyc != 2) begin
      failures++; $display("FAIL post_reset_txn: got %h/%b/%h/%b acc=%b start=%0d expected 40800000/00000/8/0 acc=00000 start=2",
                           o.result, o.flags, o.tag, o.timeout, o.acc, o.start_cyc);
    end
    ack_rsp();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_overflow_sticky();
    test_backpressure();
    test_alu_busy();
    test_random();
    test_watchdog_stale();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
